// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the Y86-64 data-memory responder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package y86_mem_pkg;

    localparam int WORD_W = 64;
    localparam int ADDR_W = 64;
    localparam int LANES  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // An 8-byte access is out of range when any of its bytes lies past the
    // end of memory. The 65-bit sum makes a wrapping address an error as well.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                      input int unsigned        mem_bytes);
        return ({1'b0, addr} + 65'd8) > 65'(mem_bytes);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage and the data memory.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response channel.
interface dmem_responder_if;
    import y86_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic              busy;

    // Memory stage side.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );

    // Data memory side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Byte-addressed storage with one 8-byte little-endian read and write port.
// Latency: read is combinational, write lands on the rising edge.
// Backpressure: none; the caller gates the write enable.
module dmem_array
    import y86_mem_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int IDX_W     = 11
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [WORD_W-1:0] o_rdata,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [WORD_W-1:0] i_wdata
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]       r_mem [MEM_BYTES];
    logic [IDX_W-1:0] w_ridx [LANES];
    logic [IDX_W-1:0] w_widx [LANES];

    // Byte address of each lane; IDX_W has one spare bit so addr+7 never wraps.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_ridx[l] = i_raddr + IDX_W'(l);
            w_widx[l] = i_waddr + IDX_W'(l);
        end
    end

    // Little-endian read assembly; lanes past the end read as zero.
    always_comb begin
        o_rdata = '0;
        for (int l = 0; l < LANES; l++) begin
            if (w_ridx[l] < IDX_W'(MEM_BYTES)) begin
                o_rdata[l*8 +: 8] = r_mem[w_ridx[l][AW-1:0]];
            end
        end
    end

    // Byte-lane write, storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int l = 0; l < LANES; l++) begin
                if (w_widx[l] < IDX_W'(MEM_BYTES)) begin
                    r_mem[w_widx[l][AW-1:0]] <= i_wdata[l*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency, single-outstanding data-memory slave for the memory stage.
// Latency: rsp_valid rises LATENCY edges after the accepting edge.
// Backpressure: response held stable until rsp_ready; req_ready low while busy.
module dmem_responder
    import y86_mem_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_responder_if.slave io_mem
);

    // One spare index bit so the lane adder in the array cannot wrap.
    localparam int IDX_W = $clog2(MEM_BYTES) + 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // WAIT spans exactly LATENCY cycles (counter LATENCY-1 down to 0), and the
    // commit happens on the edge leaving WAIT, so rsp_valid rises LATENCY edges
    // after the accept for every LATENCY, including 1.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dmem_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_write;
    logic [IDX_W-1:0]  r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_err;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [WORD_W-1:0] r_rsp_rdata;
    logic              r_rsp_error;
    logic              r_busy;

    logic              w_req_err;
    logic              w_commit;
    logic              w_we;
    logic [WORD_W-1:0] w_rdata;

    assign w_req_err = addr_err(io_mem.req_addr, MEM_BYTES);
    assign w_commit  = (r_state == WAIT) && (r_cnt == '0);
    // Reset on the commit edge wins: the write enable is killed with it.
    assign w_we      = w_commit && r_write && !r_err && rst_n;

    dmem_array #(
        .MEM_BYTES (MEM_BYTES),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_raddr (r_addr),
        .o_rdata (w_rdata),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (r_wdata)
    );

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_mem.req_valid) begin
                        r_write     <= io_mem.req_write;
                        r_addr      <= io_mem.req_addr[IDX_W-1:0];
                        r_wdata     <= io_mem.req_wdata;
                        r_err       <= w_req_err;
                        r_cnt       <= CNT_LOAD;
                        r_state     <= WAIT;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= (r_write || r_err) ? '0 : w_rdata;
                        r_rsp_error <= r_err;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (io_mem.rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_error <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign io_mem.req_ready = r_req_ready;
    assign io_mem.rsp_valid = r_rsp_valid;
    assign io_mem.rsp_rdata = r_rsp_rdata;
    assign io_mem.rsp_error = r_rsp_error;
    assign io_mem.busy      = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY=2/1024B and LATENCY=1/64B).
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low in RESP.
module tb_dmem_responder;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_d;
        logic        exp_e;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic        e;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    exp_t        q[$];
    logic [7:0]  ref_mem [1024];
    vec_t        vecs [13];
    logic [63:0] rnd_addr [10];

    dmem_responder_if if0 ();
    dmem_responder_if if1 ();

    dmem_responder #(.MEM_BYTES(1024), .LATENCY(2)) u_dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_mem (if0.slave)
    );

    dmem_responder #(.MEM_BYTES(64), .LATENCY(1)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_mem (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Byte-level reference: applies a request and returns the response it should give.
    function automatic exp_t model_apply(input logic wr, input logic [63:0] addr,
                                         input logic [63:0] wdata);
        exp_t r;
        int   base;
        r.d = '0;
        r.e = ({1'b0, addr} + 65'd8) > 65'd1024;
        if (!r.e) begin
            base = int'(addr[9:0]);
            for (int b = 0; b < 8; b++) begin
                if (wr) ref_mem[base + b] = wdata[b*8 +: 8];
                else    r.d[b*8 +: 8]     = ref_mem[base + b];
            end
        end
        return r;
    endfunction

    // Scoreboard: every completed response handshake on dut0 pops one expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (if0.rsp_valid && if0.rsp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk("rsp_rdata", if0.rsp_rdata, e.d);
                chk("rsp_error", 64'(if0.rsp_error), 64'(e.e));
            end
        end
    end

    task automatic issue0(input logic wr, input logic [63:0] addr, input logic [63:0] wdata);
        int n = 0;
        while (!if0.req_ready && n < 50) begin step(); n++; end
        if (!if0.req_ready) chk("req_ready_timeout", 64'd0, 64'd1);
        if0.req_valid = 1'b1;
        if0.req_write = wr;
        if0.req_addr  = addr;
        if0.req_wdata = wdata;
        step();
        if0.req_valid = 1'b0;
    endtask

    task automatic wait_idle0();
        int n = 0;
        while (!if0.req_ready && n < 50) begin step(); n++; end
        chk("rsp_timeout", 64'(if0.req_ready), 64'd1);
    endtask

    task automatic txn0(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                        input exp_t e);
        q.push_back(e);
        issue0(wr, addr, wdata);
        wait_idle0();
    endtask

    task automatic lat1_txn(input string nm, input logic wr, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [63:0] exp_d,
                            input logic exp_e);
        chk({nm, "_rdy0"}, 64'(if1.req_ready), 64'd1);
        if1.req_valid = 1'b1;
        if1.req_write = wr;
        if1.req_addr  = addr;
        if1.req_wdata = wdata;
        step();
        if1.req_valid = 1'b0;
        chk({nm, "_vld_e0"}, 64'(if1.rsp_valid), 64'd0);
        step();
        chk({nm, "_vld_e1"}, 64'(if1.rsp_valid), 64'd1);
        chk({nm, "_rdata"},  if1.rsp_rdata, exp_d);
        chk({nm, "_error"},  64'(if1.rsp_error), 64'(exp_e));
        step();
        chk({nm, "_vld_e2"}, 64'(if1.rsp_valid), 64'd0);
        chk({nm, "_rdy_e2"}, 64'(if1.req_ready), 64'd1);
    endtask

    task automatic chk_reset0(input string nm);
        chk({nm, "_req_ready"}, 64'(if0.req_ready), 64'd1);
        chk({nm, "_rsp_valid"}, 64'(if0.rsp_valid), 64'd0);
        chk({nm, "_rsp_rdata"}, if0.rsp_rdata, 64'd0);
        chk({nm, "_rsp_error"}, 64'(if0.rsp_error), 64'd0);
        chk({nm, "_busy"},      64'(if0.busy), 64'd0);
    endtask

    initial begin
        exp_t        e;
        logic [63:0] w;
        logic [63:0] d;
        int          n;

        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        if0.req_valid = 1'b0; if0.req_write = 1'b0; if0.req_addr = '0; if0.req_wdata = '0;
        if0.rsp_ready = 1'b1;
        if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_addr = '0; if1.req_wdata = '0;
        if1.rsp_ready = 1'b1;

        // Reset state.
        repeat (3) step();
        chk_reset0("reset");
        chk("reset1_req_ready", 64'(if1.req_ready), 64'd1);
        chk("reset1_rsp_valid", 64'(if1.rsp_valid), 64'd0);
        rst_n = 1'b1;
        step();

        // Preload: byte i holds the low 8 bits of i.
        for (int k = 0; k < 128; k++) begin
            for (int b = 0; b < 8; b++) w[b*8 +: 8] = 8'(8*k + b);
            e = model_apply(1'b1, 64'(8*k), w);
            txn0(1'b1, 64'(8*k), w, e);
        end

        // LATENCY=2 cycle timing: accept at edge 0.
        e = model_apply(1'b0, 64'd0, 64'd0);
        q.push_back(e);
        if0.req_valid = 1'b1; if0.req_write = 1'b0; if0.req_addr = 64'd0;
        step();
        if0.req_valid = 1'b0;
        chk("t_e0_req_ready", 64'(if0.req_ready), 64'd0);
        chk("t_e0_busy",      64'(if0.busy), 64'd1);
        chk("t_e0_rsp_valid", 64'(if0.rsp_valid), 64'd0);
        step();
        chk("t_e1_rsp_valid", 64'(if0.rsp_valid), 64'd0);
        step();
        chk("t_e2_rsp_valid", 64'(if0.rsp_valid), 64'd1);
        chk("t_e2_req_ready", 64'(if0.req_ready), 64'd0);
        step();
        chk("t_e3_rsp_valid", 64'(if0.rsp_valid), 64'd0);
        chk("t_e3_req_ready", 64'(if0.req_ready), 64'd1);
        chk("t_e3_busy",      64'(if0.busy), 64'd0);

        // Directed vectors (byte i preloaded with i[7:0]).
        vecs[0]  = '{1'b1, 64'd16,   64'h1122334455667788, 64'h0,                1'b0};
        vecs[1]  = '{1'b0, 64'd16,   64'h0,                64'h1122334455667788, 1'b0};
        vecs[2]  = '{1'b0, 64'd17,   64'h0,                64'h1811223344556677, 1'b0};
        vecs[3]  = '{1'b0, 64'd1016, 64'h0,                64'hFFFEFDFCFBFAF9F8, 1'b0};
        vecs[4]  = '{1'b1, 64'd1017, 64'h0123456789ABCDEF, 64'h0,                1'b1};
        vecs[5]  = '{1'b0, 64'd1016, 64'h0,                64'hFFFEFDFCFBFAF9F8, 1'b0};
        vecs[6]  = '{1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0,    64'h0,                1'b1};
        vecs[7]  = '{1'b1, 64'hFFFFFFFFFFFFFFFC, 64'h5555, 64'h0,                1'b1};
        vecs[8]  = '{1'b0, 64'd1017, 64'h0,                64'h0,                1'b1};
        vecs[9]  = '{1'b1, 64'd3,    64'hAABBCCDDEEFF0011, 64'h0,                1'b0};
        vecs[10] = '{1'b0, 64'd0,    64'h0,                64'hDDEEFF0011020100, 1'b0};
        vecs[11] = '{1'b0, 64'd8,    64'h0,                64'h0F0E0D0C0BAABBCC, 1'b0};
        vecs[12] = '{1'b0, 64'd1024, 64'h0,                64'h0,                1'b1};
        for (int i = 0; i < 13; i++) begin
            void'(model_apply(vecs[i].wr, vecs[i].addr, vecs[i].wdata));
            e.d = vecs[i].exp_d;
            e.e = vecs[i].exp_e;
            txn0(vecs[i].wr, vecs[i].addr, vecs[i].wdata, e);
        end

        // LATENCY=1 instance.
        lat1_txn("l1_wr",  1'b1, 64'd0,  64'h0000000000000005, 64'h0, 1'b0);
        lat1_txn("l1_rd",  1'b0, 64'd0,  64'h0,                64'h5, 1'b0);
        lat1_txn("l1_err", 1'b0, 64'd57, 64'h0,                64'h0, 1'b1);

        // Backpressure: response held 5 cycles, competing request ignored.
        if0.rsp_ready = 1'b0;
        e = model_apply(1'b0, 64'd16, 64'd0);
        q.push_back(e);
        issue0(1'b0, 64'd16, 64'd0);
        n = 0;
        while (!if0.rsp_valid && n < 20) begin step(); n++; end
        chk("bp_rsp_valid_seen", 64'(if0.rsp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if0.req_valid = 1'b1; if0.req_write = 1'b1;
            if0.req_addr  = 64'd40; if0.req_wdata = 64'hCAFEF00DCAFEF00D;
            step();
            chk("bp_rsp_valid", 64'(if0.rsp_valid), 64'd1);
            chk("bp_rsp_rdata", if0.rsp_rdata, 64'h1122334455667788);
            chk("bp_req_ready", 64'(if0.req_ready), 64'd0);
        end
        if0.req_valid = 1'b0;
        if0.rsp_ready = 1'b1;
        wait_idle0();
        e = model_apply(1'b0, 64'd40, 64'd0);
        txn0(1'b0, 64'd40, 64'd0, e);

        // Reset while in WAIT aborts the write.
        if0.req_valid = 1'b1; if0.req_write = 1'b1;
        if0.req_addr  = 64'd0; if0.req_wdata = 64'h00000000DEADBEEF;
        step();
        if0.req_valid = 1'b0;
        chk("abort_busy", 64'(if0.busy), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_reset0("abort");
        e = model_apply(1'b0, 64'd0, 64'd0);
        txn0(1'b0, 64'd0, 64'd0, e);

        // Reset on the commit edge: no write.
        if0.req_valid = 1'b1; if0.req_write = 1'b1;
        if0.req_addr  = 64'd8; if0.req_wdata = 64'h00000000DEADBEEF;
        step();
        if0.req_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("commit_rst_rsp_valid", 64'(if0.rsp_valid), 64'd0);
        e = model_apply(1'b0, 64'd8, 64'd0);
        txn0(1'b0, 64'd8, 64'd0, e);

        // Reset while in RESP drops the response.
        if0.rsp_ready = 1'b0;
        issue0(1'b0, 64'd16, 64'd0);
        n = 0;
        while (!if0.rsp_valid && n < 20) begin step(); n++; end
        chk("resp_rst_seen", 64'(if0.rsp_valid), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        if0.rsp_ready = 1'b1;
        chk_reset0("resp_rst");

        // Random in-range writes, then reads of the same addresses.
        for (int i = 0; i < 10; i++) begin
            rnd_addr[i] = 64'($urandom_range(0, 1016));
            d = {$urandom, $urandom};
            e = model_apply(1'b1, rnd_addr[i], d);
            txn0(1'b1, rnd_addr[i], d, e);
        end
        for (int i = 0; i < 10; i++) begin
            e = model_apply(1'b0, rnd_addr[i], 64'd0);
            txn0(1'b0, rnd_addr[i], 64'd0, e);
        end

        step();
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
